// File: rtl/bsg_fsb_pkg.sv
// rtl/bsg_fsb_pkg.sv - FSB packet header, client opcodes, FSM states and saturating helpers
package bsg_fsb_pkg;

    localparam int id_width_lp = 4;

    typedef struct packed {
        logic [id_width_lp-1:0] destid;
        logic                   cmd;
    } fsb_hdr_s;

    typedef enum logic [3:0] {
        e_op_clear    = 4'd0,
        e_op_count    = 4'd1,
        e_op_checksum = 4'd2
    } client_op_e;

    typedef enum logic [1:0] {
        e_wait_en = 2'd0,
        e_run     = 2'd1,
        e_drain   = 2'd2
    } client_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bsg_test_node_client_resp_fifo.sv
// rtl/bsg_test_node_client_resp_fifo.sv - els_p-deep 1r1w response buffer with full/empty flags
module bsg_test_node_client_resp_fifo #(
    parameter int width_p = 80,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wptr_r, rptr_r;
    logic [cnt_w_lp-1:0] count_r;

    function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            mem_r[wptr_r] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (v_i)    wptr_r <= ptr_next(wptr_r);
            if (yumi_i) rptr_r <= ptr_next(rptr_r);
            count_r <= count_r + cnt_w_lp'(v_i) - cnt_w_lp'(yumi_i);
        end
    end

    assign full_o  = (count_r == cnt_w_lp'(els_p));
    assign empty_o = (count_r == '0);
    // Zero when empty so the output bus is clean out of reset and between bursts.
    assign data_o  = empty_o ? '0 : mem_r[rptr_r];

endmodule

// File: rtl/bsg_test_node_client.sv
// rtl/bsg_test_node_client.sv - FSB ring client test node; optional BSG_TEST_NODE_CLIENT_CHECKSUM_EN adds payload checksum
module bsg_test_node_client
    import bsg_fsb_pkg::*;
#(
    parameter int ring_width_p = 80,
    parameter int master_id_p  = 0,
    parameter int client_id_p  = 1,
    parameter int fifo_els_p   = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    en_i,
    input  logic                    v_i,
    input  logic [ring_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    input  logic                    yumi_i
);

    localparam int pw_lp = ring_width_p - 5;
    localparam logic [id_width_lp-1:0] client_id_lp = id_width_lp'(client_id_p);
    localparam logic [id_width_lp-1:0] master_id_lp = id_width_lp'(master_id_p);

    client_state_e state_r, state_n;

    logic                    fifo_full, fifo_empty;
    logic                    accept, for_me;
    fsb_hdr_s                hdr_in;
    logic [pw_lp-1:0]        payload_in;
    logic [3:0]              opcode;
    logic                    resp_v;
    logic [pw_lp-1:0]        resp_payload;
    logic [ring_width_p-1:0] resp_data;
    logic                    clr, rx_inc, drop_inc;
    logic [31:0]             rx_count_r;
    logic [15:0]             drop_count_r;
    logic [pw_lp+47:0]       count_wide;
    logic [pw_lp-1:0]        checksum;

    assign hdr_in     = data_i[ring_width_p-1 -: 5];
    assign payload_in = data_i[pw_lp-1:0];
    assign opcode     = payload_in[3:0];
    assign for_me     = (hdr_in.destid == client_id_lp);
    assign accept     = v_i & ready_o;
    assign count_wide = {{pw_lp{1'b0}}, drop_count_r, rx_count_r};

    always_comb begin
        resp_v       = 1'b0;
        resp_payload = '0;
        clr          = 1'b0;
        rx_inc       = 1'b0;
        drop_inc     = 1'b0;
        if (accept) begin
            if (!for_me) begin
                drop_inc = 1'b1;
            end else if (!hdr_in.cmd) begin
                resp_v       = 1'b1;
                resp_payload = payload_in + {{(pw_lp-1){1'b0}}, 1'b1};
                rx_inc       = 1'b1;
            end else begin
                case (opcode)
                    e_op_clear:    clr = 1'b1;
                    e_op_count:    begin resp_v = 1'b1; resp_payload = count_wide[pw_lp-1:0]; end
                    e_op_checksum: begin resp_v = 1'b1; resp_payload = checksum; end
                    default:       begin resp_v = 1'b1; resp_payload = '1; end
                endcase
            end
        end
    end

    assign resp_data = {master_id_lp, 1'b0, resp_payload};

    always_ff @(posedge clk_i) begin
        if (reset_i || clr) begin
            rx_count_r   <= '0;
            drop_count_r <= '0;
        end else begin
            if (rx_inc)   rx_count_r   <= sat_inc32(rx_count_r);
            if (drop_inc) drop_count_r <= sat_inc16(drop_count_r);
        end
    end

`ifdef BSG_TEST_NODE_CLIENT_CHECKSUM_EN
    logic [pw_lp-1:0] checksum_r;
    always_ff @(posedge clk_i) begin
        if (reset_i || clr) begin
            checksum_r <= '0;
        end else if (rx_inc) begin
            checksum_r <= checksum_r ^ payload_in;
        end
    end
    assign checksum = checksum_r;
`else
    assign checksum = '0;
`endif

    bsg_test_node_client_resp_fifo #(
        .width_p(ring_width_p),
        .els_p  (fifo_els_p)
    ) resp_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (resp_v),
        .data_i (resp_data),
        .yumi_i (yumi_i & ~fifo_empty),
        .data_o (data_o),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign v_o = ~fifo_empty;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= e_wait_en;
        else         state_r <= state_n;
    end

    // ready_o depends only on registered state so a same-cycle yumi cannot open the input.
    always_comb begin
        state_n = state_r;
        ready_o = 1'b0;
        case (state_r)
            e_wait_en: if (en_i) state_n = e_run;
            e_run: begin
                ready_o = ~fifo_full;
                if (!en_i) state_n = e_drain;
            end
            e_drain: begin
                if (en_i)            state_n = e_run;
                else if (fifo_empty) state_n = e_wait_en;
            end
            default: state_n = e_wait_en;
        endcase
    end

    yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_test_node_client.sv
// tb/tb_bsg_test_node_client.sv - randomized self-checking bench with behavioural client model
module tb_bsg_test_node_client;
    import bsg_fsb_pkg::*;

    localparam int W  = 80;
    localparam int PW = W - 5;

    logic          clk_i = 1'b0;
    logic          reset_i, en_i, v_i, yumi_i;
    logic [W-1:0]  data_i;
    logic          ready_o, v_o;
    logic [W-1:0]  data_o;

    int checks = 0;
    int fails  = 0;

    logic [W-1:0]  exp_q [$];
    logic [31:0]   m_rx;
    logic [15:0]   m_drop;
    logic [PW-1:0] m_csum;

    always #5 clk_i = ~clk_i;

    bsg_test_node_client #(
        .ring_width_p(W), .master_id_p(0), .client_id_p(1), .fifo_els_p(2)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
    );

    function automatic logic [W-1:0] pkt(input logic [3:0] dest, input logic cmd, input logic [PW-1:0] pl);
        return {dest, cmd, pl};
    endfunction

    function automatic logic [PW-1:0] rand_pl();
        return PW'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_rx = 0; m_drop = 0; m_csum = 0;
    endtask

    task automatic model(input logic [W-1:0] p);
        logic [3:0]    dest = p[W-1 -: 4];
        logic          cmd  = p[W-5];
        logic [PW-1:0] pl   = p[PW-1:0];
        if (dest != 4'd1) begin
            if (m_drop != 16'hffff) m_drop = m_drop + 1;
        end else if (!cmd) begin
            exp_q.push_back({4'd0, 1'b0, pl + 75'd1});
            if (m_rx != 32'hffff_ffff) m_rx = m_rx + 1;
            m_csum = m_csum ^ pl;
        end else begin
            case (pl[3:0])
                4'd0: begin m_rx = 0; m_drop = 0; m_csum = 0; end
                4'd1: exp_q.push_back({4'd0, 1'b0, 27'd0, m_drop, m_rx});
`ifdef BSG_TEST_NODE_CLIENT_CHECKSUM_EN
                4'd2: exp_q.push_back({4'd0, 1'b0, m_csum});
`else
                4'd2: exp_q.push_back({4'd0, 1'b0, 75'd0});
`endif
                default: exp_q.push_back({4'd0, 1'b0, {PW{1'b1}}});
            endcase
        end
    endtask

    // Entered and left at a negedge; ready_o is state-only so sampling it here predicts the next edge.
    task automatic send(input logic [W-1:0] p, input string name);
        bit ok = 0;
        v_i = 1'b1; data_i = p;
        for (int i = 0; i < 50; i++) begin
            if (ready_o) begin
                @(posedge clk_i);
                model(p);
                ok = 1;
                @(negedge clk_i);
                break;
            end
            @(negedge clk_i);
        end
        v_i = 1'b0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: packet not accepted, ready_o=%0b required 1 within 50 cycles", name, ready_o);
        end
    endtask

    task automatic pop_check(input string name);
        logic [W-1:0] e;
        for (int i = 0; i < 20; i++) begin
            if (v_o) break;
            @(negedge clk_i);
        end
        checks++;
        if (v_o !== 1'b1 || exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: v_o=%0b required 1 (expected queue %0d)", name, v_o, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (data_o !== e) begin
                fails++;
                $display("FAIL %s: data_o=%h required %h", name, data_o, e);
            end
            yumi_i = 1'b1;
            @(negedge clk_i);
            yumi_i = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) pop_check(name);
    endtask

    task automatic test_reset();
        reset_i = 1'b1; en_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
        model_reset();
        repeat (3) @(negedge clk_i);
        checks++;
        if (v_o !== 1'b0 || ready_o !== 1'b0 || data_o !== '0 || dut.state_r !== e_wait_en) begin
            fails++;
            $display("FAIL reset: v_o=%0b ready_o=%0b data_o=%h state=%0d required 0/0/0/wait_en",
                     v_o, ready_o, data_o, dut.state_r);
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b0) begin
            fails++;
            $display("FAIL wait_en_ready: ready_o=%0b required 0", ready_o);
        end
        en_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin
            fails++;
            $display("FAIL run_ready: ready_o=%0b required 1", ready_o);
        end
    endtask

    task automatic test_single();
        checks++;
        if (v_o !== 1'b0) begin
            fails++;
            $display("FAIL single_pre: v_o=%0b required 0", v_o);
        end
        send(pkt(4'd1, 1'b0, 75'd5), "single_send");
        checks++;
        if (v_o !== 1'b1 || data_o !== {4'd0, 1'b0, 75'd6}) begin
            fails++;
            $display("FAIL single_latency: v_o=%0b data_o=%h required 1/%h", v_o, data_o, {4'd0, 1'b0, 75'd6});
        end
        pop_check("single_resp");
        checks++;
        if (v_o !== 1'b0) begin
            fails++;
            $display("FAIL single_once: v_o=%0b required 0", v_o);
        end
        send(pkt(4'd1, 1'b0, {PW{1'b1}}), "wrap_send");
        pop_check("wrap_resp");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e;
        send(pkt(4'd1, 1'b0, 75'h11), "bp_a");
        send(pkt(4'd1, 1'b0, 75'h22), "bp_b");
        v_i = 1'b1; data_i = pkt(4'd1, 1'b0, 75'h33);
        repeat (3) begin
            checks++;
            if (ready_o !== 1'b0) begin
                fails++;
                $display("FAIL bp_blocked: ready_o=%0b required 0", ready_o);
            end
            @(negedge clk_i);
        end
        e = exp_q.pop_front();
        checks++;
        if (ready_o !== 1'b0 || v_o !== 1'b1 || data_o !== e) begin
            fails++;
            $display("FAIL bp_pulse: ready_o=%0b v_o=%0b data_o=%h required 0/1/%h", ready_o, v_o, data_o, e);
        end
        yumi_i = 1'b1;
        @(negedge clk_i);
        yumi_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin
            fails++;
            $display("FAIL bp_reopen: ready_o=%0b required 1", ready_o);
        end
        send(pkt(4'd1, 1'b0, 75'h33), "bp_c");
        drain("bp_order");
    endtask

    task automatic test_counting();
        send(pkt(4'd1, 1'b1, 75'd0), "cnt_clear0");
        for (int i = 0; i < 3; i++) begin
            send(pkt(4'd1, 1'b0, rand_pl()), "cnt_data");
            pop_check("cnt_data_resp");
        end
        send(pkt(4'd2, 1'b0, rand_pl()), "cnt_drop");
        send(pkt(4'd1, 1'b1, 75'd1), "cnt_read");
        checks++;
        if (data_o !== {4'd0, 1'b0, 27'd0, 16'd1, 32'd3}) begin
            fails++;
            $display("FAIL cnt_value: data_o=%h required %h", data_o, {4'd0, 1'b0, 27'd0, 16'd1, 32'd3});
        end
        pop_check("cnt_read_resp");
        send(pkt(4'd1, 1'b1, 75'd0), "cnt_clear");
        send(pkt(4'd1, 1'b1, 75'd1), "cnt_read0");
        pop_check("cnt_read0_resp");
    endtask

    task automatic test_checksum();
        send(pkt(4'd1, 1'b1, 75'd0), "cs_clear");
        send(pkt(4'd1, 1'b0, 75'h3), "cs_d3");
        send(pkt(4'd1, 1'b0, 75'h5), "cs_d5");
        drain("cs_data");
        send(pkt(4'd1, 1'b1, 75'd2), "cs_read");
        pop_check("cs_read_resp");
        send(pkt(4'd1, 1'b1, 75'd7), "cs_op7");
        pop_check("cs_op7_resp");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [3:0]    dest;
            logic          cmd;
            logic [PW-1:0] pl;
            if (exp_q.size() >= 2) drain("rand_resp");
            dest = ($urandom_range(0, 3) == 0) ? 4'd2 : 4'd1;
            cmd  = ($urandom_range(0, 2) == 0);
            pl   = rand_pl();
            if (cmd) pl[3:0] = 4'($urandom_range(0, 8));
            send(pkt(dest, cmd, pl), "rand_send");
        end
        send(pkt(4'd1, 1'b1, 75'd1), "rand_count");
        drain("rand_resp");
    endtask

    task automatic test_enable();
        send(pkt(4'd1, 1'b0, 75'h40), "en_a");
        send(pkt(4'd1, 1'b0, 75'h41), "en_b");
        en_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b0 || dut.state_r !== e_drain) begin
            fails++;
            $display("FAIL en_drain: ready_o=%0b state=%0d required 0/drain", ready_o, dut.state_r);
        end
        pop_check("en_resp_a");
        checks++;
        if (ready_o !== 1'b0) begin
            fails++;
            $display("FAIL en_ready_hold: ready_o=%0b required 0", ready_o);
        end
        pop_check("en_resp_b");
        @(negedge clk_i);
        checks++;
        if (dut.state_r !== e_wait_en || ready_o !== 1'b0) begin
            fails++;
            $display("FAIL en_wait: state=%0d ready_o=%0b required wait_en/0", dut.state_r, ready_o);
        end
        en_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_mid_reset();
        send(pkt(4'd2, 1'b0, 75'd9), "mr_drop");
        send(pkt(4'd1, 1'b0, 75'd9), "mr_data");
        checks++;
        if (v_o !== 1'b1) begin
            fails++;
            $display("FAIL mr_pending: v_o=%0b required 1", v_o);
        end
        reset_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (v_o !== 1'b0 || data_o !== '0) begin
            fails++;
            $display("FAIL mr_flush: v_o=%0b data_o=%h required 0/0", v_o, data_o);
        end
        reset_i = 1'b0;
        model_reset();
        send(pkt(4'd1, 1'b1, 75'd1), "mr_read");
        pop_check("mr_read_resp");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_counting();
        test_checksum();
        test_random();
        test_enable();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
